dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Single-port data-memory responder for a CPU-side initiator. Each request is
// captured in IDLE. It then spends WAIT_CYCLES cycles in WAIT and completes
// with a one-cycle RESP, during which ack_o is high. Misaligned addresses and
// word indices beyond DEPTH_WORDS are reported through err_o and never touch
// the storage.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (power of two, 4..1024)
//   WAIT_CYCLES  wait-state cycles inserted per access (0..15)
//
// Ports
//   clk_i     in   1   clock, all state updates on the rising edge
//   rst_i     in   1   asynchronous active-high reset
//   req_i     in   1   access request, sampled in IDLE only
//   we_i      in   1   1 = write, 0 = read
//   addr_i    in  32   byte address
//   wdata_i   in  32   write data
//   rdata_o   out 32   registered read data, held between read responses
//   ack_o     out  1   one-cycle completion strobe (RESP state)
//   err_o     out  1   error flag, only ever high together with ack_o
//   busy_o    out  1   high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Fields of the access that completes on this edge. With WAIT_CYCLES = 0
    // the access enters RESP on the same edge that accepts it, so the live
    // inputs have to be used because the capture registers are not loaded yet.
    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             enter_resp;
    logic             mem_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        if (state_q == S_IDLE) begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_LIM);
        acc_idx = acc_addr[IDX_W+1:2];

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (HAS_WAIT) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response data and error flag are produced on the edge entering RESP;
        // err_d defaults to 0 so the flag drops again as RESP is left.
        if (enter_resp) begin
            err_d = acc_err;
            if (!acc_we) begin
                rdata_d = acc_err ? 32'd0 : mem[acc_idx];
            end
        end

        // Gating with rst_i keeps a zero-wait write from landing while reset
        // is held with req_i high.
        mem_we = enter_resp && acc_we && !acc_err && !rst_i;
    end

    // Control and capture registers; storage is deliberately left unreset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = (state_q == S_RESP);
    assign err_o   = err_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Two instances share the clock and reset:
// dut_w2 uses WAIT_CYCLES = 2 and dut_w0 uses WAIT_CYCLES = 0, both with
// DEPTH_WORDS = 128. The expected values are worked out by hand from the
// access protocol.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        req2, we2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        ack2, err2, busy2;

    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ack0, err0, busy0;

    int vectors;
    int miscompares;

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut_w2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req2),
        .we_i    (we2),
        .addr_i  (addr2),
        .wdata_i (wdata2),
        .rdata_o (rdata2),
        .ack_o   (ack2),
        .err_o   (err2),
        .busy_o  (busy2)
    );

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut_w0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req0),
        .we_i    (we0),
        .addr_i  (addr0),
        .wdata_i (wdata0),
        .rdata_o (rdata0),
        .ack_o   (ack0),
        .err_o   (err0),
        .busy_o  (busy0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hang anywhere in the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One complete access on the selected instance. The request is presented
    // for the accepting edge only. lat counts edges after the accepting edge
    // until ack is seen (99 when it never arrives). busy_n counts the sampled
    // cycles with busy high, and ack_next is ack one cycle after the strobe.
    task automatic applyStimulus(input bit use_w0, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic er,
                                 output int lat, output int busy_n,
                                 output logic ack_next);
        logic seen;
        if (use_w0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req2 = 1'b0;
        lat = 0;
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (use_w0 ? busy0 : busy2) busy_n++;
            if (use_w0 ? ack0 : ack2) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!seen) lat = 99;
        rd = use_w0 ? rdata0 : rdata2;
        er = use_w0 ? err0 : err2;
        @(posedge clk); #1;
        ack_next = use_w0 ? ack0 : ack2;
        if (use_w0 ? busy0 : busy2) busy_n++;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        ack_next;
        int          lat;
        int          busy_n;
        int          ack_count;
        logic [15:0] pattern;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        req2 = 1'b0; we2 = 1'b0; addr2 = 32'd0; wdata2 = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;

        // Reset values.
        #2;
        checkOutput("rst_rdata", rdata2, 32'd0);
        checkOutput("rst_ack", {31'd0, ack2}, 32'd0);
        checkOutput("rst_err", {31'd0, err2}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pre-clear 0x20 so the aborted write below is observable.
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("preclear_err", {31'd0, er}, 32'd0);

        // Write then read 0x10: ack two edges after the accepting edge.
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, busy_n, ack_next);
        checkOutput("wr10_latency", 32'(lat), 32'd2);
        checkOutput("wr10_err", {31'd0, er}, 32'd0);
        checkOutput("wr10_rdata_held", rd, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd10_latency", 32'(lat), 32'd2);
        checkOutput("rd10_data", rd, 32'hDEADBEEF);
        checkOutput("rd10_err", {31'd0, er}, 32'd0);
        checkOutput("rd10_ack_one_cycle", {31'd0, ack_next}, 32'd0);
        checkOutput("rd10_busy_cycles", 32'(busy_n), 32'd3);
        checkOutput("rd10_err_after", {31'd0, err2}, 32'd0);

        // Misaligned and out-of-range reads.
        applyStimulus(1'b0, 1'b0, 32'h13, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd13_err", {31'd0, er}, 32'd1);
        checkOutput("rd13_data", rd, 32'd0);
        checkOutput("rd13_latency", 32'(lat), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd200_err", {31'd0, er}, 32'd1);
        checkOutput("rd200_data", rd, 32'd0);
        checkOutput("rd200_err_drop", {31'd0, err2}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h1FC, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd1fc_last_word_err", {31'd0, er}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd10_again", rd, 32'hDEADBEEF);

        // Misaligned write must not disturb memory or rdata.
        applyStimulus(1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, rd, er, lat, busy_n, ack_next);
        checkOutput("wr11_err", {31'd0, er}, 32'd1);
        checkOutput("wr11_rdata_held", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd10_after_bad_wr", rd, 32'hDEADBEEF);

        // Reset during WAIT of a write to 0x20 aborts it.
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'hCAFEF00D;
        @(posedge clk); #1;
        req2 = 1'b0;
        checkOutput("abort_busy_before", {31'd0, busy2}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy2}, 32'd0);
        checkOutput("abort_rdata", rdata2, 32'd0);
        checkOutput("abort_ack", {31'd0, ack2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ack_count = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack2) ack_count++;
        end
        checkOutput("abort_no_ack", 32'(ack_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("rd20_after_abort", rd, 32'd0);

        // Continuous request: ack every 4 cycles, req dropped inside WAIT.
        req2 = 1'b1; we2 = 1'b0; addr2 = 32'h10; wdata2 = 32'h0;
        @(posedge clk); #1;
        pattern = 16'd0;
        for (int k = 1; k <= 16; k++) begin
            req2 = ((k - 1) % 4 == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            pattern[k-1] = ack2;
        end
        req2 = 1'b0;
        checkOutput("hold_ack_pattern", {16'd0, pattern}, 32'h0000_2222);
        checkOutput("hold_rdata", rdata2, 32'hDEADBEEF);
        repeat (5) @(posedge clk);
        #1;

        // Zero wait states: ack right after acceptance, busy for one cycle.
        applyStimulus(1'b1, 1'b1, 32'h04, 32'h12345678, rd, er, lat, busy_n, ack_next);
        checkOutput("w0_wr_latency", 32'(lat), 32'd0);
        checkOutput("w0_wr_err", {31'd0, er}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h04, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("w0_rd_latency", 32'(lat), 32'd0);
        checkOutput("w0_rd_data", rd, 32'h12345678);
        checkOutput("w0_busy_cycles", 32'(busy_n), 32'd1);
        checkOutput("w0_ack_one_cycle", {31'd0, ack_next}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h06, 32'h0, rd, er, lat, busy_n, ack_next);
        checkOutput("w0_misaligned_err", {31'd0, er}, 32'd1);
        checkOutput("w0_misaligned_data", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
